// File: rtl/rv32_fetch.sv
// rv32 instruction fetch stage: fetch PC, imem read handshake, static branch
// prediction and a one-entry skid buffer feeding the decode slot registers.
//
// state    | meaning
// FETCH    | issuing requests from pc
// BUFFERED | skid buffer holds a response/exception captured under stall
// HALT     | exception delivered, waiting for trap or mispredict redirect
module rv32_fetch #(
    parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
    parameter bit          PREDICT_ENABLE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        flush_in,
    input  logic        trap_in,
    input  logic [31:0] trap_pc_in,
    input  logic        branch_mispredicted_in,
    input  logic [31:0] branch_pc_in,
    output logic        instr_read_out,
    output logic [31:0] instr_address_out,
    input  logic        instr_ready_in,
    input  logic        instr_fault_in,
    input  logic [31:0] instr_read_value_in,
    output logic        valid_out,
    output logic        exception_out,
    output logic [3:0]  exception_cause_out,
    output logic        branch_predicted_taken_out,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out
);

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        BUFFERED = 2'd1,
        HALT     = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q;

    logic        buf_exc;
    logic [3:0]  buf_cause;
    logic        buf_taken;
    logic [31:0] buf_pc;
    logic [31:0] buf_instr;

    logic        redirect;
    logic [31:0] redirect_pc;
    logic        misaligned;
    logic        fetch_have;
    logic        new_exc;
    logic [3:0]  new_cause;
    logic        new_taken;
    logic [31:0] new_instr;
    logic [31:0] j_imm, b_imm;
    logic [31:0] next_pc;
    logic        pred_taken;
    logic        slot_src_new, slot_src_buf;

    assign redirect          = trap_in | branch_mispredicted_in;
    assign redirect_pc       = trap_in ? trap_pc_in : branch_pc_in;
    assign misaligned        = (pc_q[1:0] != 2'b00);
    assign instr_address_out = pc_q;

    // A misaligned pc yields an exception without waiting for the memory.
    assign fetch_have = (state_q == FETCH) && (misaligned || instr_ready_in);
    assign new_exc    = misaligned || instr_fault_in;
    assign new_cause  = misaligned ? 4'd0 : 4'd1;
    assign new_taken  = !new_exc && pred_taken;
    assign new_instr  = new_exc ? 32'd0 : instr_read_value_in;

    assign j_imm = {{12{instr_read_value_in[31]}}, instr_read_value_in[19:12],
                    instr_read_value_in[20], instr_read_value_in[30:21], 1'b0};
    assign b_imm = {{20{instr_read_value_in[31]}}, instr_read_value_in[7],
                    instr_read_value_in[30:25], instr_read_value_in[11:8], 1'b0};

    always_comb begin
        pred_taken = 1'b0;
        next_pc    = pc_q + 32'd4;
        if (PREDICT_ENABLE) begin
            if (instr_read_value_in[6:0] == 7'b1101111) begin
                pred_taken = 1'b1;
                next_pc    = pc_q + j_imm;
            end else if (instr_read_value_in[6:0] == 7'b1100011 && instr_read_value_in[31]) begin
                pred_taken = 1'b1;
                next_pc    = pc_q + b_imm;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect) begin
            state_d = FETCH;
        end else begin
            case (state_q)
                FETCH: begin
                    if (fetch_have) begin
                        if (stall_in) begin
                            state_d = BUFFERED;
                        end else if (new_exc) begin
                            state_d = HALT;
                        end
                    end
                end
                BUFFERED: begin
                    if (!stall_in) begin
                        state_d = buf_exc ? HALT : FETCH;
                    end
                end
                default: state_d = HALT;
            endcase
        end
    end

    always_comb begin
        instr_read_out = (state_q == FETCH) && !misaligned;
    end

    // Anything not loaded from a new response or the buffer becomes a bubble.
    always_comb begin
        slot_src_new = 1'b0;
        slot_src_buf = 1'b0;
        if (!redirect && !flush_in) begin
            slot_src_new = fetch_have;
            slot_src_buf = (state_q == BUFFERED);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q                       <= RESET_VECTOR;
            valid_out                  <= 1'b0;
            exception_out              <= 1'b0;
            exception_cause_out        <= 4'd0;
            branch_predicted_taken_out <= 1'b0;
            pc_out                     <= 32'd0;
            instr_out                  <= 32'd0;
            buf_exc                    <= 1'b0;
            buf_cause                  <= 4'd0;
            buf_taken                  <= 1'b0;
            buf_pc                     <= 32'd0;
            buf_instr                  <= 32'd0;
        end else begin
            if (redirect) begin
                pc_q <= redirect_pc;
            end else if (fetch_have && !new_exc) begin
                pc_q <= next_pc;
            end

            if (!redirect && fetch_have && stall_in) begin
                buf_exc   <= new_exc;
                buf_cause <= new_cause;
                buf_taken <= new_taken;
                buf_pc    <= pc_q;
                buf_instr <= new_instr;
            end

            if (!stall_in) begin
                if (slot_src_new) begin
                    valid_out                  <= !new_exc;
                    exception_out              <= new_exc;
                    exception_cause_out        <= new_exc ? new_cause : 4'd0;
                    branch_predicted_taken_out <= new_taken;
                    pc_out                     <= pc_q;
                    instr_out                  <= new_instr;
                end else if (slot_src_buf) begin
                    valid_out                  <= !buf_exc;
                    exception_out              <= buf_exc;
                    exception_cause_out        <= buf_exc ? buf_cause : 4'd0;
                    branch_predicted_taken_out <= buf_taken;
                    pc_out                     <= buf_pc;
                    instr_out                  <= buf_instr;
                end else begin
                    valid_out                  <= 1'b0;
                    exception_out              <= 1'b0;
                    exception_cause_out        <= 4'd0;
                    branch_predicted_taken_out <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rv32_fetch.sv
// Bench for rv32_fetch: directed scenarios plus randomized traffic checked
// against a transaction-level model (pc, halted flag, skid queue, slot).
module tb_rv32_fetch;

    logic        clk = 1'b0;
    logic        reset, stall_in, flush_in, trap_in, branch_mispredicted_in;
    logic [31:0] trap_pc_in, branch_pc_in;
    logic        instr_ready_in, instr_fault_in;
    logic [31:0] mem [0:255];

    logic        a_read, a_valid, a_exc, a_taken;
    logic [31:0] a_addr, a_pc, a_instr, a_rdata;
    logic [3:0]  a_cause;
    logic        b_read, b_valid, b_exc, b_taken;
    logic [31:0] b_addr, b_pc, b_instr, b_rdata;
    logic [3:0]  b_cause;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign a_rdata = mem[a_addr[9:2]];
    assign b_rdata = mem[b_addr[9:2]];

    rv32_fetch #(.RESET_VECTOR(32'h100), .PREDICT_ENABLE(1'b1)) dut_a (
        .clk(clk), .reset(reset), .stall_in(stall_in), .flush_in(flush_in),
        .trap_in(trap_in), .trap_pc_in(trap_pc_in),
        .branch_mispredicted_in(branch_mispredicted_in), .branch_pc_in(branch_pc_in),
        .instr_read_out(a_read), .instr_address_out(a_addr),
        .instr_ready_in(instr_ready_in), .instr_fault_in(instr_fault_in),
        .instr_read_value_in(a_rdata), .valid_out(a_valid), .exception_out(a_exc),
        .exception_cause_out(a_cause), .branch_predicted_taken_out(a_taken),
        .pc_out(a_pc), .instr_out(a_instr)
    );

    rv32_fetch #(.RESET_VECTOR(32'h100), .PREDICT_ENABLE(1'b0)) dut_b (
        .clk(clk), .reset(reset), .stall_in(stall_in), .flush_in(flush_in),
        .trap_in(trap_in), .trap_pc_in(trap_pc_in),
        .branch_mispredicted_in(branch_mispredicted_in), .branch_pc_in(branch_pc_in),
        .instr_read_out(b_read), .instr_address_out(b_addr),
        .instr_ready_in(instr_ready_in), .instr_fault_in(instr_fault_in),
        .instr_read_value_in(b_rdata), .valid_out(b_valid), .exception_out(b_exc),
        .exception_cause_out(b_cause), .branch_predicted_taken_out(b_taken),
        .pc_out(b_pc), .instr_out(b_instr)
    );

    // Reference model of dut_a (prediction enabled).
    typedef struct packed {
        logic        valid;
        logic        exc;
        logic [3:0]  cause;
        logic        taken;
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t      m_slot;
    entry_t      m_skid[$];
    logic [31:0] m_pc;
    bit          m_halt;

    function automatic void predict(input logic [31:0] pc, input logic [31:0] w,
                                    output logic [31:0] nxt, output logic tk);
        int off;
        tk  = 1'b0;
        nxt = pc + 32'd4;
        if (w[6:0] == 7'b1101111) begin
            off = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
            nxt = pc + 32'(off);
            tk  = 1'b1;
        end else if (w[6:0] == 7'b1100011 && w[31]) begin
            off = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
            nxt = pc + 32'(off);
            tk  = 1'b1;
        end
    endfunction

    entry_t      me;
    logic [31:0] mw, mnxt;
    logic        mtk, mhave;

    always @(posedge clk) begin
        if (reset) begin
            m_pc   = 32'h100;
            m_halt = 1'b0;
            m_skid.delete();
            m_slot = '0;
        end else if (trap_in || branch_mispredicted_in) begin
            m_pc   = trap_in ? trap_pc_in : branch_pc_in;
            m_halt = 1'b0;
            m_skid.delete();
            if (!stall_in) begin
                m_slot.valid = 1'b0; m_slot.exc = 1'b0; m_slot.cause = 4'd0; m_slot.taken = 1'b0;
            end
        end else if (m_skid.size() != 0) begin
            if (!stall_in) begin
                me     = m_skid.pop_front();
                m_halt = me.exc;
                if (flush_in) begin
                    m_slot.valid = 1'b0; m_slot.exc = 1'b0; m_slot.cause = 4'd0; m_slot.taken = 1'b0;
                end else begin
                    m_slot = me;
                end
            end
        end else if (m_halt) begin
            if (!stall_in) begin
                m_slot.valid = 1'b0; m_slot.exc = 1'b0; m_slot.cause = 4'd0; m_slot.taken = 1'b0;
            end
        end else begin
            mhave = 1'b0;
            me    = '0;
            if (m_pc[1:0] != 2'b00) begin
                mhave = 1'b1; me.exc = 1'b1; me.cause = 4'd0; me.pc = m_pc;
            end else if (instr_ready_in) begin
                mhave = 1'b1;
                me.pc = m_pc;
                if (instr_fault_in) begin
                    me.exc = 1'b1; me.cause = 4'd1;
                end else begin
                    mw = mem[m_pc[9:2]];
                    predict(m_pc, mw, mnxt, mtk);
                    me.valid = 1'b1; me.instr = mw; me.taken = mtk;
                    m_pc = mnxt;
                end
            end
            if (mhave && stall_in) begin
                m_skid.push_back(me);
            end else if (!stall_in) begin
                if (mhave) m_halt = me.exc;
                if (mhave && !flush_in) begin
                    m_slot = me;
                end else begin
                    m_slot.valid = 1'b0; m_slot.exc = 1'b0; m_slot.cause = 4'd0; m_slot.taken = 1'b0;
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1; trap_in = 1'b1; trap_pc_in = 32'h55;
        repeat (3) @(negedge clk);
        checks++; if (a_addr !== 32'h100) begin errors++; $display("FAIL reset_addr got %h want %h", a_addr, 32'h100); end
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", a_valid); end
        checks++; if (a_exc !== 1'b0 || a_cause !== 4'd0 || a_taken !== 1'b0) begin errors++; $display("FAIL reset_flags got exc %b cause %0d taken %b want 0 0 0", a_exc, a_cause, a_taken); end
        checks++; if (a_pc !== 32'd0 || a_instr !== 32'd0) begin errors++; $display("FAIL reset_slot got pc %h instr %h want 0 0", a_pc, a_instr); end
        reset = 1'b0; trap_in = 1'b0;
        #1;
        checks++; if (a_read !== 1'b1) begin errors++; $display("FAIL reset_read got %b want 1", a_read); end
        @(negedge clk);
        checks++; if (a_addr !== 32'h104) begin errors++; $display("FAIL seq_addr1 got %h want %h", a_addr, 32'h104); end
        checks++; if (a_valid !== 1'b1 || a_pc !== 32'h100 || a_instr !== 32'h13 || a_taken !== 1'b0) begin errors++; $display("FAIL seq_slot1 got v %b pc %h instr %h tk %b want 1 100 13 0", a_valid, a_pc, a_instr, a_taken); end
        @(negedge clk);
        checks++; if (a_addr !== 32'h108 || a_pc !== 32'h104) begin errors++; $display("FAIL seq_slot2 got addr %h pc %h want 108 104", a_addr, a_pc); end
    endtask

    task automatic test_predict();
        mem[8'h80] = 32'hFE000EE3;
        trap_in = 1'b1; trap_pc_in = 32'h200;
        @(negedge clk);
        trap_in = 1'b0;
        checks++; if (a_addr !== 32'h200 || b_addr !== 32'h200) begin errors++; $display("FAIL redirect_addr got a %h b %h want 200", a_addr, b_addr); end
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL redirect_bubble got %b want 0", a_valid); end
        @(negedge clk);
        checks++; if (a_addr !== 32'h1FC) begin errors++; $display("FAIL pred_next got %h want %h", a_addr, 32'h1FC); end
        checks++; if (a_taken !== 1'b1 || a_valid !== 1'b1 || a_pc !== 32'h200 || a_instr !== 32'hFE000EE3) begin errors++; $display("FAIL pred_slot got tk %b v %b pc %h instr %h", a_taken, a_valid, a_pc, a_instr); end
        checks++; if (b_addr !== 32'h204 || b_taken !== 1'b0 || b_valid !== 1'b1) begin errors++; $display("FAIL nopred got addr %h tk %b v %b want 204 0 1", b_addr, b_taken, b_valid); end
        @(negedge clk);
        checks++; if (a_addr !== 32'h200) begin errors++; $display("FAIL pred_loop got %h want 200", a_addr); end
        mem[8'h80] = 32'h13;
    endtask

    task automatic test_stall_skid();
        trap_in = 1'b1; trap_pc_in = 32'h3C;
        @(negedge clk);
        trap_in = 1'b0;
        @(negedge clk);
        checks++; if (a_valid !== 1'b1 || a_pc !== 32'h3C || a_addr !== 32'h40) begin errors++; $display("FAIL pre_stall got v %b pc %h addr %h", a_valid, a_pc, a_addr); end
        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (a_read !== 1'b0 || a_addr !== 32'h44) begin errors++; $display("FAIL buffered_read cyc %0d got rd %b addr %h want 0 44", i, a_read, a_addr); end
            checks++; if (a_valid !== 1'b1 || a_pc !== 32'h3C || a_instr !== 32'h13) begin errors++; $display("FAIL frozen cyc %0d got v %b pc %h instr %h", i, a_valid, a_pc, a_instr); end
        end
        stall_in = 1'b0;
        @(negedge clk);
        checks++; if (a_valid !== 1'b1 || a_pc !== 32'h40 || a_read !== 1'b1 || a_addr !== 32'h44) begin errors++; $display("FAIL unstall got v %b pc %h rd %b addr %h", a_valid, a_pc, a_read, a_addr); end
        @(negedge clk);
        checks++; if (a_pc !== 32'h44 || a_addr !== 32'h48) begin errors++; $display("FAIL resume got pc %h addr %h want 44 48", a_pc, a_addr); end
    endtask

    task automatic test_fault_trap();
        trap_in = 1'b1; trap_pc_in = 32'h80;
        @(negedge clk);
        trap_in = 1'b0; instr_fault_in = 1'b1;
        checks++; if (a_read !== 1'b1 || a_addr !== 32'h80) begin errors++; $display("FAIL fault_req got rd %b addr %h", a_read, a_addr); end
        @(negedge clk);
        instr_fault_in = 1'b0;
        checks++; if (a_exc !== 1'b1 || a_cause !== 4'd1 || a_valid !== 1'b0 || a_pc !== 32'h80) begin errors++; $display("FAIL fault_slot got exc %b cause %0d v %b pc %h", a_exc, a_cause, a_valid, a_pc); end
        checks++; if (a_read !== 1'b0 || a_addr !== 32'h80) begin errors++; $display("FAIL fault_halt got rd %b addr %h want 0 80", a_read, a_addr); end
        @(negedge clk);
        checks++; if (a_read !== 1'b0 || a_exc !== 1'b0 || a_valid !== 1'b0) begin errors++; $display("FAIL halt_bubble got rd %b exc %b v %b", a_read, a_exc, a_valid); end
        trap_in = 1'b1; trap_pc_in = 32'h10;
        @(negedge clk);
        trap_in = 1'b0;
        checks++; if (a_addr !== 32'h10 || a_read !== 1'b1) begin errors++; $display("FAIL trap_resume got addr %h rd %b", a_addr, a_read); end
        @(negedge clk);
        checks++; if (a_valid !== 1'b1 || a_pc !== 32'h10) begin errors++; $display("FAIL trap_slot got v %b pc %h", a_valid, a_pc); end
    endtask

    task automatic test_misaligned_flush();
        branch_mispredicted_in = 1'b1; branch_pc_in = 32'h302;
        @(negedge clk);
        branch_mispredicted_in = 1'b0;
        checks++; if (a_read !== 1'b0 || a_addr !== 32'h302) begin errors++; $display("FAIL misal_req got rd %b addr %h", a_read, a_addr); end
        @(negedge clk);
        checks++; if (a_exc !== 1'b1 || a_cause !== 4'd0 || a_valid !== 1'b0 || a_pc !== 32'h302) begin errors++; $display("FAIL misal_slot got exc %b cause %0d v %b pc %h", a_exc, a_cause, a_valid, a_pc); end
        trap_in = 1'b1; trap_pc_in = 32'h20;
        @(negedge clk);
        trap_in = 1'b0; stall_in = 1'b1;
        checks++; if (a_addr !== 32'h20 || a_read !== 1'b1) begin errors++; $display("FAIL flush_pre got addr %h rd %b", a_addr, a_read); end
        @(negedge clk);
        checks++; if (a_read !== 1'b0 || a_addr !== 32'h24) begin errors++; $display("FAIL flush_buffered got rd %b addr %h", a_read, a_addr); end
        branch_mispredicted_in = 1'b1; branch_pc_in = 32'h60; flush_in = 1'b1; stall_in = 1'b0;
        @(negedge clk);
        branch_mispredicted_in = 1'b0; flush_in = 1'b0;
        checks++; if (a_valid !== 1'b0 || a_addr !== 32'h60) begin errors++; $display("FAIL flush_drop got v %b addr %h", a_valid, a_addr); end
        @(negedge clk);
        checks++; if (a_valid !== 1'b1 || a_pc !== 32'h60) begin errors++; $display("FAIL flush_target got v %b pc %h want 1 60", a_valid, a_pc); end
    endtask

    task automatic test_random();
        logic [31:0] w;
        logic        exp_read;
        for (int i = 0; i < 256; i++) begin
            w = $urandom;
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: w[6:0] = 7'h13;
                5, 6:          w[6:0] = 7'b1101111;
                7, 8:          w[6:0] = 7'b1100011;
                default:       ;
            endcase
            mem[i] = w;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            exp_read = !m_halt && (m_skid.size() == 0) && (m_pc[1:0] == 2'b00);
            checks++; if (a_addr !== m_pc) begin errors++; $display("FAIL rnd_addr cyc %0d got %h want %h", cyc, a_addr, m_pc); end
            checks++; if (a_read !== exp_read) begin errors++; $display("FAIL rnd_read cyc %0d got %b want %b", cyc, a_read, exp_read); end
            checks++; if (a_valid !== m_slot.valid) begin errors++; $display("FAIL rnd_valid cyc %0d got %b want %b", cyc, a_valid, m_slot.valid); end
            checks++; if (a_exc !== m_slot.exc || a_cause !== m_slot.cause) begin errors++; $display("FAIL rnd_exc cyc %0d got %b/%0d want %b/%0d", cyc, a_exc, a_cause, m_slot.exc, m_slot.cause); end
            checks++; if (a_taken !== m_slot.taken) begin errors++; $display("FAIL rnd_taken cyc %0d got %b want %b", cyc, a_taken, m_slot.taken); end
            if (m_slot.valid || m_slot.exc) begin
                checks++; if (a_pc !== m_slot.pc) begin errors++; $display("FAIL rnd_pc cyc %0d got %h want %h", cyc, a_pc, m_slot.pc); end
            end
            if (m_slot.valid) begin
                checks++; if (a_instr !== m_slot.instr) begin errors++; $display("FAIL rnd_instr cyc %0d got %h want %h", cyc, a_instr, m_slot.instr); end
            end
            reset                  = ($urandom_range(0, 199) == 0);
            stall_in               = ($urandom_range(0, 9) < 3);
            instr_ready_in         = ($urandom_range(0, 9) < 7);
            instr_fault_in         = ($urandom_range(0, 19) == 0);
            flush_in               = ($urandom_range(0, 19) == 0);
            trap_in                = ($urandom_range(0, 39) == 0);
            branch_mispredicted_in = ($urandom_range(0, 29) == 0);
            trap_pc_in             = $urandom & 32'h3FC;
            branch_pc_in           = $urandom & 32'h3FC;
            if ($urandom_range(0, 9) == 0) trap_pc_in[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 9) == 0) branch_pc_in[1:0] = 2'($urandom_range(1, 3));
        end
        reset = 1'b0; stall_in = 1'b0; flush_in = 1'b0; trap_in = 1'b0;
        branch_mispredicted_in = 1'b0; instr_fault_in = 1'b0; instr_ready_in = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
        reset = 1'b1; stall_in = 1'b0; flush_in = 1'b0;
        trap_in = 1'b0; trap_pc_in = 32'd0;
        branch_mispredicted_in = 1'b0; branch_pc_in = 32'd0;
        instr_ready_in = 1'b1; instr_fault_in = 1'b0;
        test_reset();
        test_predict();
        test_stall_skid();
        test_fault_trap();
        test_misaligned_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32_fetch.md
Name: rv32_fetch

Overview:
- Instruction fetch stage of the rv32 pipeline, directly upstream of decode.
- Keeps the fetch PC and drives the instruction-memory read handshake.
- Applies static branch prediction and holds a one-entry skid buffer for responses that arrive while decode is stalled.
- Registers valid/exception/cause/predicted-taken/pc/instr into decode's inputs.

Parameters:
RESET_VECTOR, 32'h00000000, fetch address loaded on reset
PREDICT_ENABLE, 1, 1 = static prediction (JAL taken, backward conditional branch taken); 0 = always pc+4

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
stall_in  input  1  from hazard unit: freeze output registers
flush_in  input  1  from hazard unit: squash the output slot
trap_in  input  1  redirect to trap_pc_in (highest priority)
trap_pc_in  input  32  trap/mret target
branch_mispredicted_in  input  1  redirect to branch_pc_in
branch_pc_in  input  32  corrected branch target
instr_read_out  output  1  fetch request
instr_address_out  output  32  fetch address, equals internal pc
instr_ready_in  input  1  response valid this cycle for the current address
instr_fault_in  input  1  access fault, qualified by instr_ready_in
instr_read_value_in  input  32  fetched instruction word
valid_out  output  1  slot holds an instruction for decode
exception_out  output  1  slot carries a fetch exception
exception_cause_out  output  4  0 = misaligned, 1 = access fault
branch_predicted_taken_out  output  1  prediction applied to this slot
pc_out  output  32  slot PC
instr_out  output  32  slot instruction

Behaviour:
- Reset values: pc=RESET_VECTOR, state=FETCH. All outputs 0 (instr_out=0, pc_out=0). Reset overrides every other input in the same cycle.
- States:
  - FETCH: issuing requests.
  - BUFFERED: skid buffer full.
  - HALT: exception emitted, waiting for a redirect.
- instr_read_out=1 only in FETCH with pc[1:0]==0. The memory is combinational-accept, so the address may change while not ready.
- Next-PC prediction on the fetched word w (only when PREDICT_ENABLE=1; otherwise next = pc+4, taken=0):
  - JAL (w[6:0]==7'b1101111): next = pc + sign-extended J-imm, taken=1.
  - BRANCH (w[6:0]==7'b1100011) with w[31]==1: next = pc + sign-extended B-imm, taken=1.
  - Otherwise: next = pc+4, taken=0.
  - All adds are 32-bit and wrap modulo 2^32.
- FETCH, instr_ready_in=1, no fault:
  - stall_in=0: load the output slot (valid=1, exception=0, pc, instr, taken) and set pc=next.
  - stall_in=1: capture pc/word/taken into the skid buffer, set pc=next, go to BUFFERED. Outputs hold.
- FETCH, instr_ready_in=1, fault: deliver (or buffer, if stalled) a slot with valid=0, exception=1, cause=1, then go to HALT. Fault wins over prediction, and pc does not advance.
- FETCH, pc[1:0]!=0: no request issued. Slot gets exception=1, cause=0, valid=0; go to HALT. Same stall/buffer rule as a fault.
- FETCH, instr_ready_in=0, stall_in=0: slot gets valid=0, exception=0 (bubble).
- BUFFERED: instr_read_out=0. When stall_in=0, move the buffer into the slot and return to FETCH (or to HALT if the buffered entry was an exception).
- HALT: instr_read_out=0. When stall_in=0, the slot is a bubble. Leave HALT only on a redirect.
- Redirect:
  - trap_in has priority over branch_mispredicted_in.
  - Sets pc to the target, clears the skid buffer, state=FETCH.
  - Applies regardless of stall_in.
  - A response arriving in the redirect cycle is discarded.
- flush_in with stall_in=0: slot gets valid/exception/taken = 0, and replaces any load that cycle. flush_in has no effect while stall_in=1.
- pc_out/instr_out on bubbles: don't-care, but must be held when stall_in=1.

Test Plan:
- Reset with RESET_VECTOR=0x100, memory always ready with NOP 0x00000013 -> instr_address_out 0x100, 0x104, 0x108; valid_out=1 from cycle 2; taken=0.
- Word 0xFE000EE3 (beq x0,x0,-4) at 0x200 -> next address 0x1FC, branch_predicted_taken_out=1. Same test with PREDICT_ENABLE=0 -> 0x204, taken=0.
- stall_in=1 for 3 cycles while the response for 0x40 arrives -> outputs frozen, instr_read_out=0 in BUFFERED; on release, pc_out=0x40, then fetch resumes at 0x44 with no duplicate or lost word.
- instr_fault_in at 0x80 -> exception_out=1, cause=1, valid_out=0, reads stop; trap_in with trap_pc_in=0x10 -> fetch resumes at 0x10.
- branch_mispredicted_in to 0x302 -> no read issued, exception_out=1, cause=0. Redirect during BUFFERED with flush_in=1 -> buffer dropped and the next valid pc_out is the target.
